// File: rtl/gpu_raster_arbiter.sv
// Round-robin owner arbiter for the framebuffer pixel-write port: grants one raster
// engine per primitive and muxes its pixel stream. Optional watchdog: GPU_ARB_TIMEOUT_EN.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif

module gpu_raster_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            done_i,
  input  logic [NUM_REQ-1:0]            busy_i,
  input  logic [NUM_REQ*`WIDTH_BITS-1:0]  x_i,
  input  logic [NUM_REQ*`HEIGHT_BITS-1:0] y_i,
  output logic [NUM_REQ-1:0]            start_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [IW-1:0]                 owner_o,
  output logic                          wr_valid_o,
  output logic [`WIDTH_BITS-1:0]        wr_x_o,
  output logic [`HEIGHT_BITS-1:0]       wr_y_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic [1:0]                    dbg_state_o
);

  localparam int XW = `WIDTH_BITS;
  localparam int YW = `HEIGHT_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_OWN   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic          done_q, done_d;
  logic [IW-1:0] pick;
  int unsigned   cand;
  logic          timeout_hit;

  // Scan from last+1 with wrap; iterating downward leaves the nearest requester in pick.
  always_comb begin
    pick = '0;
    cand = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(last_q) + i) % NUM_REQ;
      if (req_i[cand]) pick = IW'(cand);
    end
  end

`ifdef GPU_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // done_i has priority over the watchdog in the same cycle.
  assign timeout_hit = (state_q == S_OWN) && (cnt_q == 16'(TIMEOUT_CYCLES - 1))
                       && !done_i[owner_q];

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_START)    cnt_d = '0;
    else if (state_q == S_OWN) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = pick;
          state_d = S_START;
        end
      end
      S_START: state_d = S_OWN;
      S_OWN: begin
        if (done_i[owner_q]) begin
          last_d  = owner_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  logic          own;
  logic [NUM_REQ-1:0] owner_1h;

  assign own      = (state_q == S_OWN);
  assign owner_1h = NUM_REQ'(1) << owner_q;

  assign grant_o     = (state_q != S_IDLE) ? owner_1h : '0;
  assign start_o     = (state_q == S_START) ? owner_1h : '0;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign timeout_o   = timeout_hit;
  assign dbg_state_o = state_q;

  // Pixel path is a pure combinational mux of the owner's slices, zero when not owning.
  assign wr_valid_o = own & busy_i[owner_q];
  assign wr_x_o     = own ? x_i[int'(owner_q)*XW +: XW] : '0;
  assign wr_y_o     = own ? y_i[int'(owner_q)*YW +: YW] : '0;

endmodule

// File: tb/tb_gpu_raster_arbiter.sv
// Randomized bench for gpu_raster_arbiter: engine models, a transaction-level
// ownership model, a pixel scoreboard and directed scenarios for the arbitration rules.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif

module tb_gpu_raster_arbiter;
  localparam int N  = 3;
  localparam int T  = 16;
  localparam int XW = `WIDTH_BITS;
  localparam int YW = `HEIGHT_BITS;
  localparam int PW = XW + YW;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_i, done_i, busy_i;
  logic [N*XW-1:0] x_i;
  logic [N*YW-1:0] y_i;
  logic [N-1:0] start_o, grant_o;
  logic [$clog2(N)-1:0] owner_o;
  logic wr_valid_o, busy_o, done_o, timeout_o;
  logic [XW-1:0] wr_x_o;
  logic [YW-1:0] wr_y_o;
  logic [1:0] dbg_state_o;

  gpu_raster_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .done_i(done_i), .busy_i(busy_i),
    .x_i(x_i), .y_i(y_i), .start_o(start_o), .grant_o(grant_o), .owner_o(owner_o),
    .wr_valid_o(wr_valid_o), .wr_x_o(wr_x_o), .wr_y_o(wr_y_o), .busy_o(busy_o),
    .done_o(done_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // ---------------- reference model (ownership level) ----------------
  int m_owner = -1;      // -1: nobody owns the port
  bit m_started = 0;     // start pulse already issued for this owner
  int m_last = N - 1;
  int m_owner_reg = 0;
  bit m_done_pend = 0;
  int m_own_cyc = 0;

  // ---------------- engines ----------------
  int rx0[N], ry0[N], rw[N], rh[N], cx[N], cy[N], left_px[N];
  bit hang[N];
  bit rand_rect = 0;
  bit noise = 0;
  int stall_pct = 0;

  // ---------------- scoreboard / stats ----------------
  logic [PW-1:0] exp_q[$];
  int owner_exp_q[$];
  int cycle = 0;
  int pix_seen = 0, done_seen = 0, timeouts_seen = 0;
  int min_x, max_x, min_y, max_y;
  int start_cycle = 0, last_done_cycle = 0, timeout_cycle = 0;
  bit have_done = 0, gap_chk = 0;
  logic [N-1:0] s_grant;
  logic s_busy, s_wv;

  task automatic check_outputs();
    logic [N-1:0] e_grant, e_start;
    logic e_wv, e_to;
    logic [XW-1:0] e_x;
    logic [YW-1:0] e_y;
    logic [PW-1:0] p;
    bit own;
    own = (m_owner >= 0) && m_started;
    e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e_start = (m_owner >= 0 && !m_started) ? e_grant : '0;
    e_wv = 1'b0; e_x = '0; e_y = '0; e_to = 1'b0;
    if (own) begin
      e_wv = busy_i[m_owner];
      e_x  = x_i[m_owner*XW +: XW];
      e_y  = y_i[m_owner*YW +: YW];
`ifdef GPU_ARB_TIMEOUT_EN
      e_to = (m_own_cyc == T - 1) && !done_i[m_owner];
`endif
    end
    check("grant", 32'(grant_o), 32'(e_grant));
    check("start", 32'(start_o), 32'(e_start));
    check("owner", 32'(owner_o), 32'(m_owner_reg));
    check("busy", 32'(busy_o), 32'(m_owner >= 0));
    check("done", 32'(done_o), 32'(m_done_pend));
    check("timeout", 32'(timeout_o), 32'(e_to));
    check("wr_valid", 32'(wr_valid_o), 32'(e_wv));
    check("wr_x", 32'(wr_x_o), 32'(e_x));
    check("wr_y", 32'(wr_y_o), 32'(e_y));
    if (wr_valid_o) begin
      pix_seen++;
      if (int'(wr_x_o) < min_x) min_x = int'(wr_x_o);
      if (int'(wr_x_o) > max_x) max_x = int'(wr_x_o);
      if (int'(wr_y_o) < min_y) min_y = int'(wr_y_o);
      if (int'(wr_y_o) > max_y) max_y = int'(wr_y_o);
      if (exp_q.size() == 0) check("pix_extra", 32'(wr_valid_o), 32'd0);
      else begin
        p = exp_q.pop_front();
        check("pix", 32'({wr_x_o, wr_y_o}), 32'(p));
      end
    end
    if (start_o != '0) begin
      start_cycle = cycle;
      for (int k = 0; k < N; k++)
        if (start_o[k] && owner_exp_q.size() > 0) check("start_owner", k, owner_exp_q.pop_front());
      if (gap_chk && have_done) check("start_gap", cycle - last_done_cycle, 2);
    end
    if (own && done_i[m_owner]) begin last_done_cycle = cycle; have_done = 1; end
    if (done_o) done_seen++;
    if (timeout_o) begin timeouts_seen++; timeout_cycle = cycle; end
    s_grant = grant_o; s_busy = busy_o; s_wv = wr_valid_o;
  endtask

  task automatic model_update();
    int c;
    if (rst) begin
      m_owner = -1; m_started = 0; m_last = N - 1; m_owner_reg = 0;
      m_done_pend = 0; m_own_cyc = 0; have_done = 0;
      for (int k = 0; k < N; k++) left_px[k] = 0;
      exp_q.delete();
    end else begin
      m_done_pend = 0;
      if (m_owner < 0) begin
        if (req_i != '0) begin
          for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (req_i[c]) begin m_owner = c; break; end
          end
          m_started = 0;
          m_owner_reg = m_owner;
        end
      end else if (!m_started) begin
        m_started = 1; m_own_cyc = 0;
      end else if (done_i[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_done_pend = 1;
`ifdef GPU_ARB_TIMEOUT_EN
      end else if (m_own_cyc == T - 1) begin
        m_last = m_owner; m_owner = -1;
`endif
      end else m_own_cyc++;
    end
  endtask

  task automatic drive_engines();
    for (int k = 0; k < N; k++) begin
      busy_i[k] = 1'b0;
      done_i[k] = 1'b0;
      x_i[k*XW +: XW] = XW'($urandom);
      y_i[k*YW +: YW] = YW'($urandom);
      if (m_owner == k && !m_started) begin
        if (rand_rect) begin
          rx0[k] = $urandom_range(0, 200); ry0[k] = $urandom_range(0, 200);
          rw[k] = $urandom_range(1, 4); rh[k] = $urandom_range(1, 3);
        end
        cx[k] = 0; cy[k] = 0; left_px[k] = rw[k] * rh[k];
      end
      if (m_owner == k && m_started) begin
        if (left_px[k] > 0) begin
          if ($urandom_range(0, 99) >= stall_pct) begin
            busy_i[k] = 1'b1;
            x_i[k*XW +: XW] = XW'(rx0[k] + cx[k]);
            y_i[k*YW +: YW] = YW'(ry0[k] + cy[k]);
            exp_q.push_back({XW'(rx0[k] + cx[k]), YW'(ry0[k] + cy[k])});
            left_px[k]--;
            if (cx[k] == rw[k] - 1) begin cx[k] = 0; cy[k]++; end
            else cx[k]++;
          end
        end else if (!hang[k]) done_i[k] = 1'b1;
      end else if (noise) begin
        busy_i[k] = 1'($urandom_range(0, 1));
        done_i[k] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    drive_engines();
    cycle++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; req_i = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic request(input logic [N-1:0] mask);
    int n;
    req_i = mask;
    n = 0;
    while (m_owner < 0 && n < 20) begin tick(); n++; end
    if (m_owner < 0) check("grant_wait", 0, 1);
  endtask

  task automatic run_until_dones(input int target, input int budget);
    int n;
    n = 0;
    while (done_seen < target && n < budget) begin tick(); n++; end
    if (done_seen < target) check("done_wait", done_seen, target);
  endtask

  task automatic drain();
    int n;
    req_i = '0;
    n = 0;
    while ((m_owner >= 0 || m_done_pend) && n < 500) begin tick(); n++; end
    if (m_owner >= 0) check("drain_wait", 0, 1);
  endtask

  task automatic clear_stats();
    pix_seen = 0; min_x = 1 << 30; max_x = -1; min_y = 1 << 30; max_y = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst = 1'b1; req_i = '0; done_i = '0; busy_i = '0; x_i = '0; y_i = '0;
    for (int k = 0; k < N; k++) begin
      hang[k] = 0; rx0[k] = 0; ry0[k] = 0; rw[k] = 1; rh[k] = 1; left_px[k] = 0;
    end
    @(posedge clk); #1;
    do_reset();

    // fill_rect (0,0)-(5,6) on engine 0
    rx0[0] = 0; ry0[0] = 0; rw[0] = 6; rh[0] = 7;
    clear_stats();
    owner_exp_q.push_back(0);
    request(3'b001);
    req_i = '0;
    run_until_dones(1, 200);
    check("t1_pixels", pix_seen, 42);
    check("t1_xmin", min_x, 0); check("t1_xmax", max_x, 5);
    check("t1_ymin", min_y, 0); check("t1_ymax", max_y, 6);
    tick();
    check("t1_grant_idle", 32'(s_grant), 0);

    // all requesting from reset: order 0,1,2,0 with 2-cycle gaps
    do_reset();
    rand_rect = 1; gap_chk = 1;
    d0 = done_seen;
    owner_exp_q = '{0, 1, 2, 0};
    req_i = 3'b111;
    run_until_dones(d0 + 4, 400);
    check("t2_order_left", owner_exp_q.size(), 0);
    owner_exp_q.delete();
    gap_chk = 0;
    drain();

    // owner 1 finishes, then 0 and 1 request: 0 wins
    do_reset();
    d0 = done_seen;
    owner_exp_q.push_back(1);
    request(3'b010);
    req_i = '0;
    run_until_dones(d0 + 1, 200);
    owner_exp_q.push_back(0);
    request(3'b011);
    req_i = '0;
    drain();
    check("t3_order_left", owner_exp_q.size(), 0);

    // non-owner noise while engine 0 owns
    noise = 1; stall_pct = 30;
    d0 = done_seen;
    owner_exp_q.push_back(0);
    request(3'b001);
    req_i = '0;
    run_until_dones(d0 + 1, 200);
    noise = 0; stall_pct = 0;
    drain();

    // reset mid-primitive after 10 pixels
    rand_rect = 0;
    rx0[0] = 10; ry0[0] = 20; rw[0] = 8; rh[0] = 8;
    clear_stats();
    request(3'b001);
    req_i = '0;
    for (int n = 0; n < 100 && pix_seen < 10; n++) tick();
    check("t5_pixels", pix_seen, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_i = 3'b110;
    tick();
    check("t5_grant", 32'(s_grant), 0);
    check("t5_wv", 32'(s_wv), 0);
    check("t5_busy", 32'(s_busy), 0);
    owner_exp_q.push_back(1);
    rw[1] = 3; rh[1] = 2;
    request(3'b110);
    req_i = '0;
    drain();
    check("t5_order_left", owner_exp_q.size(), 0);

    // owner never finishes
    do_reset();
    hang[0] = 1; rw[0] = 0; rh[0] = 0;
    d0 = done_seen;
    timeouts_seen = 0;
    request(3'b001);
    req_i = '0;
`ifdef GPU_ARB_TIMEOUT_EN
    for (int n = 0; n < 100 && timeouts_seen == 0; n++) tick();
    check("t6_timeouts", timeouts_seen, 1);
    check("t6_to_cycle", timeout_cycle - start_cycle, T);
    tick();
    check("t6_busy_after", 32'(s_busy), 0);
`else
    for (int n = 0; n < 1000; n++) tick();
    check("t6_timeouts", timeouts_seen, 0);
    check("t6_grant_held", 32'(s_grant), 32'b001);
`endif
    check("t6_no_done", done_seen, d0);
    hang[0] = 0;
    do_reset();

    // randomized traffic
    rand_rect = 1; noise = 1; stall_pct = 25;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req_i = N'($urandom_range(0, (1 << N) - 1));
      tick();
    end
    noise = 0;
    drain();
    tick();
    check("final_exp_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
